uart_alu_cmd_master: RTL and testbench

//  Host-side initiator for the UART ALU command protocol. On i_start it serializes one
//  ALU transaction through a byte-wide UART TX: 0x00,A / 0x01,B / 0x03,op / 0x02.
//  It then waits for the single result byte on UART RX. Sits between a local

---
 rtl/uart_alu_pkg.sv | 38 +++
 rtl/uart_alu_cmd_master_cycle_timeout_counter.sv | 41 ++++
 rtl/uart_alu_cmd_master.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_alu_cmd_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// ---------------------------------------------------------------------------
// uart_alu_pkg
// Shared definitions for the UART ALU command master: protocol opcode bytes,
// FSM state encoding and the step-selection helper used when cached operand
// pairs are skipped.
// ---------------------------------------------------------------------------
package uart_alu_pkg;

  localparam logic [7:0] OP_LOAD_A     = 8'h00;
  localparam logic [7:0] OP_LOAD_B     = 8'h01;
  localparam logic [7:0] OP_GET_RESULT = 8'h02;
  localparam logic [7:0] OP_LOAD_OP    = 8'h03;
  localparam logic [7:0] ERR_BYTE      = 8'hFF;

  // Step 6 is the trailing GET_RESULT byte; steps 0..5 are three 2-byte pairs.
  localparam logic [2:0] LAST_STEP = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_TX = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // First step of the lowest pair at or after from_pair that is not skipped.
  // Pair 0 = A, pair 1 = B, pair 2 = op, pair 3 = GET_RESULT (never skipped).
  function automatic logic [2:0] first_needed_step(input logic [1:0] from_pair,
                                                   input logic [2:0] skip);
    logic [2:0] s;
    s = LAST_STEP;
    if (from_pair <= 2'd2 && !skip[2]) s = 3'd4;
    if (from_pair <= 2'd1 && !skip[1]) s = 3'd2;
    if (from_pair == 2'd0 && !skip[0]) s = 3'd0;
    return s;
  endfunction

endpackage

// File: rtl/uart_alu_cmd_master_cycle_timeout_counter.sv
// ---------------------------------------------------------------------------
// cycle_timeout_counter
// Response timer. Loaded with TIMEOUT_CYCLES-1 while clear is high, counts
// down while enable is high, and flags expired on terminal count (zero).
// Entering the counted phase right after a clear, expired rises in the
// TIMEOUT_CYCLES-th enabled cycle.
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous reset, active-low
//   clear      reload the counter
//   enable     count one cycle
//   expired    terminal count reached
// ---------------------------------------------------------------------------
module cycle_timeout_counter #(
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [NB_TIMEOUT-1:0] LOAD_VAL = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_alu_cmd_master.sv
// ---------------------------------------------------------------------------
// uart_alu_cmd_master
// Host-side initiator for the UART ALU command protocol. On i_start it sends
// 00,A / 01,B / 03,op / 02 through a byte-wide UART TX, then waits for one
// result byte on UART RX (or a timeout).
//
// Optional feature macro: UART_ALU_CMD_MASTER_CACHE_EN
//   When defined, A/B/op of the last successful transaction are cached and
//   any pair whose field matches the cache is not resent.
//
// Ports:
//   i_clk, i_reset_n           clock / async active-low reset
//   i_start                    begin transaction (sampled in IDLE only)
//   i_data_A, i_data_B         operands, latched on accepted start
//   i_alu_op                   operator, latched on accepted start
//   i_tx_done                  UART TX finished current byte
//   i_rx_done, i_rx_data       UART RX byte strobe and data
//   o_tx_data, o_tx_start      byte and 1-cycle request to UART TX
//   o_busy                     transaction in progress
//   o_done                     1-cycle completion pulse
//   o_result, o_timeout        result byte / no-response flag, held to next done
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for i_start
// ST_LOAD_TX | present byte[step] and pulse o_tx_start
// ST_WAIT_TX | waiting for i_tx_done of the current byte
// ST_WAIT_RX | all bytes sent, timing the response
// ST_DONE    | o_done pulse, back to IDLE
// ---------------------------------------------------------------------------
module uart_alu_cmd_master
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_ALU_OP      = 6,
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [NB_DATA-1:0]   i_data_A,
  input  logic [NB_DATA-1:0]   i_data_B,
  input  logic [NB_ALU_OP-1:0] i_alu_op,
  input  logic                 i_tx_done,
  input  logic                 i_rx_done,
  input  logic [NB_DATA-1:0]   i_rx_data,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_timeout
);

  state_t                state;
  logic [2:0]            step;
  logic [NB_DATA-1:0]    a_q;
  logic [NB_DATA-1:0]    b_q;
  logic [NB_ALU_OP-1:0]  op_q;
  logic [2:0]            skip_q;
  logic [NB_DATA-1:0]    rx_hold;
  logic                  rx_hold_valid;
  logic [NB_DATA-1:0]    tx_byte;
  logic [2:0]            skip_in;
  logic                  tmo_expired;

  // Skip mask {op, B, A} evaluated against the incoming operands at start.
`ifdef UART_ALU_CMD_MASTER_CACHE_EN
  logic                 cache_valid;
  logic [NB_DATA-1:0]   cache_a;
  logic [NB_DATA-1:0]   cache_b;
  logic [NB_ALU_OP-1:0] cache_op;

  // DONE is the one cycle where o_timeout already reflects the finished
  // transaction and the latched operands are still those that were sent.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cache_valid <= 1'b0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_op    <= '0;
    end else if (state == ST_DONE) begin
      if (o_timeout) begin
        cache_valid <= 1'b0;
      end else begin
        cache_valid <= 1'b1;
        cache_a     <= a_q;
        cache_b     <= b_q;
        cache_op    <= op_q;
      end
    end
  end

  assign skip_in = {cache_valid && (i_alu_op == cache_op),
                    cache_valid && (i_data_B == cache_b),
                    cache_valid && (i_data_A == cache_a)};
`else
  assign skip_in = 3'b000;
`endif

  always_comb begin
    tx_byte = NB_DATA'(ERR_BYTE);
    case (step)
      3'd0:    tx_byte = NB_DATA'(OP_LOAD_A);
      3'd1:    tx_byte = a_q;
      3'd2:    tx_byte = NB_DATA'(OP_LOAD_B);
      3'd3:    tx_byte = b_q;
      3'd4:    tx_byte = NB_DATA'(OP_LOAD_OP);
      3'd5:    tx_byte = {{(NB_DATA-NB_ALU_OP){1'b0}}, op_q};
      3'd6:    tx_byte = NB_DATA'(OP_GET_RESULT);
      default: tx_byte = NB_DATA'(ERR_BYTE);
    endcase
  end

  // Reloaded during every WAIT_TX cycle, so it is fresh on WAIT_RX entry.
  cycle_timeout_counter #(
    .NB_TIMEOUT     (NB_TIMEOUT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .clear     (state == ST_WAIT_TX),
    .enable    (state == ST_WAIT_RX),
    .expired   (tmo_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      step          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      skip_q        <= '0;
      rx_hold       <= '0;
      rx_hold_valid <= 1'b0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_result      <= '0;
      o_timeout     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            a_q           <= i_data_A;
            b_q           <= i_data_B;
            op_q          <= i_alu_op;
            skip_q        <= skip_in;
            step          <= first_needed_step(2'd0, skip_in);
            rx_hold_valid <= 1'b0;
            o_busy        <= 1'b1;
            state         <= ST_LOAD_TX;
          end
        end

        ST_LOAD_TX: begin
          o_tx_data  <= tx_byte;
          o_tx_start <= 1'b1;
          state      <= ST_WAIT_TX;
        end

        ST_WAIT_TX: begin
          if (i_tx_done) begin
            if (step != LAST_STEP) begin
              // After a data byte (odd step) move to the next pair still needed.
              step  <= step[0] ? first_needed_step(step[2:1] + 2'd1, skip_q)
                               : step + 3'd1;
              state <= ST_LOAD_TX;
            end else if (i_rx_done) begin
              o_result  <= i_rx_data;
              o_timeout <= 1'b0;
              o_done    <= 1'b1;
              o_busy    <= 1'b0;
              state     <= ST_DONE;
            end else if (rx_hold_valid) begin
              o_result  <= rx_hold;
              o_timeout <= 1'b0;
              o_done    <= 1'b1;
              o_busy    <= 1'b0;
              state     <= ST_DONE;
            end else begin
              state <= ST_WAIT_RX;
            end
          end else if (i_rx_done && (step == LAST_STEP)) begin
            // Remote answered before our TX reported the 0x02 byte done.
            rx_hold       <= i_rx_data;
            rx_hold_valid <= 1'b1;
          end
        end

        ST_WAIT_RX: begin
          if (i_rx_done) begin
            o_result  <= i_rx_data;
            o_timeout <= 1'b0;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            state     <= ST_DONE;
          end else if (tmo_expired) begin
            o_result  <= '0;
            o_timeout <= 1'b1;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_cmd_master.sv
module tb_uart_alu_cmd_master;

  localparam int TMO = 50;

  localparam int M_NORMAL = 0;
  localparam int M_SILENT = 1;
  localparam int M_SAME   = 2;
  localparam int M_POKE   = 3;
  localparam int M_RESET  = 4;
  localparam int M_EARLY  = 5;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_data_A = '0;
  logic [7:0] i_data_B = '0;
  logic [5:0] i_alu_op = '0;
  logic       i_tx_done = 1'b0;
  logic       i_rx_done = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_result;
  logic       o_timeout;

  uart_alu_cmd_master #(
    .NB_DATA        (8),
    .NB_ALU_OP      (6),
    .NB_TIMEOUT     (20),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_start    (i_start),
    .i_data_A   (i_data_A),
    .i_data_B   (i_data_B),
    .i_alu_op   (i_alu_op),
    .i_tx_done  (i_tx_done),
    .i_rx_done  (i_rx_done),
    .i_rx_data  (i_rx_data),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] result;
    logic       timeout;
  } res_t;

  logic [7:0] exp_tx_q[$];
  res_t       exp_res_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference cache state (only consulted when the cache feature is built).
  bit         m_valid = 1'b0;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;
  logic [5:0] m_op = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_expected(input logic [7:0] a, input logic [7:0] b,
                               input logic [5:0] op, input int mode,
                               input logic [7:0] resp);
    bit   skip_a, skip_b, skip_op;
    res_t r;
    skip_a  = 1'b0;
    skip_b  = 1'b0;
    skip_op = 1'b0;
`ifdef UART_ALU_CMD_MASTER_CACHE_EN
    skip_a  = m_valid && (a == m_a);
    skip_b  = m_valid && (b == m_b);
    skip_op = m_valid && (op == m_op);
`endif
    if (!skip_a)  begin exp_tx_q.push_back(8'h00); exp_tx_q.push_back(a); end
    if (!skip_b)  begin exp_tx_q.push_back(8'h01); exp_tx_q.push_back(b); end
    if (!skip_op) begin exp_tx_q.push_back(8'h03); exp_tx_q.push_back({2'b00, op}); end
    exp_tx_q.push_back(8'h02);
    r.result  = (mode == M_SILENT) ? 8'h00 : resp;
    r.timeout = (mode == M_SILENT);
    exp_res_q.push_back(r);
  endtask

  // Called at #1 after a posedge; returns at #1 after a posedge.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] op, input int mode,
                         input logic [7:0] resp);
    int         cyc, tx_cnt, tx_cd, rx_cd, txdone_cyc, first_tx;
    bit         last, done, early_rx;
    res_t       r;
    logic [7:0] e;
    push_expected(a, b, op, mode, resp);
    i_data_A = a;
    i_data_B = b;
    i_alu_op = op;
    i_start  = 1'b1;
    cyc = 0; tx_cnt = 0; tx_cd = 0; rx_cd = 0;
    txdone_cyc = -1; first_tx = -1;
    last = 1'b0; done = 1'b0; early_rx = 1'b0;
    while (!done && cyc < TMO + 300) begin
      @(posedge i_clk); #1;
      cyc++;
      i_start   = 1'b0;
      i_tx_done = 1'b0;
      i_rx_done = 1'b0;
      if (cyc == 1) check("busy_after_start", o_busy, 1);
      if (o_tx_start) begin
        tx_cnt++;
        if (first_tx < 0) begin
          first_tx = cyc;
          check("start_to_first_tx", cyc, 2);
        end
        if (exp_tx_q.size() == 0) begin
          check("tx_unexpected_byte", o_tx_data, 32'hFFFF_FFFF);
          last = 1'b0;
        end else begin
          e = exp_tx_q.pop_front();
          check("tx_byte", o_tx_data, e);
          last = (exp_tx_q.size() == 0);
        end
        tx_cd = 2;
        if (last && mode == M_EARLY) early_rx = 1'b1;
        if (mode == M_RESET && tx_cnt == 3) begin
          i_reset_n = 1'b0;
          #1;
          check("async_reset_outputs",
                {o_tx_start, o_busy, o_done, o_timeout, o_result, o_tx_data}, 0);
          exp_tx_q.delete();
          exp_res_q.delete();
          m_valid = 1'b0;
          @(negedge i_clk);
          @(negedge i_clk);
          check("reset_held_outputs", {o_tx_start, o_busy, o_result}, 0);
          i_reset_n = 1'b1;
          @(posedge i_clk); #1;
          return;
        end
      end
      if (o_done) begin
        done = 1'b1;
        check("busy_low_at_done", o_busy, 0);
        check("tx_missing_bytes", exp_tx_q.size(), 0);
        if (exp_res_q.size() == 0) begin
          check("done_unexpected", o_done, 0);
        end else begin
          r = exp_res_q.pop_front();
          check("result", o_result, r.result);
          check("timeout_flag", o_timeout, r.timeout);
          if (r.timeout) begin
            check("timeout_latency", cyc - txdone_cyc, TMO + 1);
            m_valid = 1'b0;
          end else begin
            m_valid = 1'b1;
            m_a = a;
            m_b = b;
            m_op = op;
          end
        end
        if (mode == M_SAME || mode == M_EARLY)
          check("done_after_last_tx_done", cyc - txdone_cyc, 1);
      end else begin
        if (early_rx) begin
          i_rx_done = 1'b1;
          i_rx_data = resp;
          early_rx  = 1'b0;
        end else if (tx_cd > 0) begin
          tx_cd--;
          if (tx_cd == 0) begin
            i_tx_done = 1'b1;
            if (last) begin
              txdone_cyc = cyc;
              if (mode == M_SAME) begin
                i_rx_done = 1'b1;
                i_rx_data = resp;
              end else if (mode != M_SILENT && mode != M_EARLY) begin
                rx_cd = 3;
              end
            end
          end
        end else if (rx_cd > 0) begin
          rx_cd--;
          if (rx_cd == 0) begin
            i_rx_done = 1'b1;
            i_rx_data = resp;
          end
        end
        if (mode == M_POKE && cyc == 4) begin
          i_start  = 1'b1;
          i_data_A = 8'hAA;
        end
      end
    end
    if (!done) check("done_seen", o_done, 1);
    i_data_A = a;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      check("idle_no_tx_start", o_tx_start, 0);
      check("idle_not_busy", o_busy, 0);
    end
  endtask

  initial begin
    i_reset_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_tx_start", o_tx_start, 0);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_result", o_result, 0);
    check("reset_timeout", o_timeout, 0);
    check("reset_tx_data", o_tx_data, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    run_txn(8'h05, 8'h03, 6'h20, M_NORMAL, 8'h08);
    run_txn(8'h09, 8'h04, 6'h22, M_POKE,   8'h05);
    check("poke_result_held", o_result, 8'h05);
    run_txn(8'h11, 8'h22, 6'h24, M_RESET,  8'h00);
    run_txn(8'h05, 8'h03, 6'h20, M_NORMAL, 8'h08);
    run_txn(8'h10, 8'h20, 6'h25, M_SAME,   8'h5A);
    run_txn(8'h10, 8'h20, 6'h25, M_SILENT, 8'h00);
    run_txn(8'h33, 8'h44, 6'h20, M_EARLY,  8'h77);
`ifdef UART_ALU_CMD_MASTER_CACHE_EN
    run_txn(8'h33, 8'h44, 6'h20, M_NORMAL, 8'h77);
    run_txn(8'h33, 8'h07, 6'h20, M_NORMAL, 8'h3A);
    run_txn(8'h40, 8'h07, 6'h22, M_NORMAL, 8'h39);
`else
    run_txn(8'h33, 8'h44, 6'h20, M_NORMAL, 8'h77);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
